// File: rtl/note_tone_gen.sv
// Multi-channel note-to-square-wave generator: note/octave codes map to half-period dividers,
// each channel runs an IDLE/PLAY/RELEASE FSM with boundary-aligned pitch changes and a release tail.
module note_tone_gen #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned DIV_W    = 22,
    parameter int unsigned HOLD_CYC = 5_000_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stop,
    input  logic [4*NUM_CH-1:0]       note,
    input  logic [2*NUM_CH-1:0]       octave,
    output logic [NUM_CH-1:0]         tone_out,
    output logic [NUM_CH-1:0]         active,
    output logic [DIV_W*NUM_CH-1:0]   cur_div
);

    localparam int unsigned HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    function automatic int unsigned calc_base(input int unsigned freq_hz);
        return CLK_HZ / (2 * freq_hz) - 1;
    endfunction

    localparam int unsigned BASE_C_FULL = calc_base(262);

    // Index 0 and 13..15 are key-up codes and never loaded.
    localparam logic [DIV_W-1:0] BASE [16] = '{
        '0,
        DIV_W'(calc_base(262)), DIV_W'(calc_base(277)), DIV_W'(calc_base(294)),
        DIV_W'(calc_base(311)), DIV_W'(calc_base(330)), DIV_W'(calc_base(349)),
        DIV_W'(calc_base(370)), DIV_W'(calc_base(392)), DIV_W'(calc_base(415)),
        DIV_W'(calc_base(440)), DIV_W'(calc_base(466)), DIV_W'(calc_base(494)),
        '0, '0, '0
    };

    if (64'(BASE_C_FULL) >= (64'd1 << DIV_W)) begin : g_div_w_check
        $error("note_tone_gen: DIV_W too narrow for lowest note divider");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t              state_q, state_d;
        logic [DIV_W-1:0]    cnt_q, cnt_d;
        logic [DIV_W-1:0]    div_q, div_d;
        logic [HOLD_W-1:0]   hold_q, hold_d;
        logic [3:0]          lat_note_q, lat_note_d;
        logic [1:0]          lat_oct_q, lat_oct_d;
        logic                tone_q, tone_d;
        logic                active_q, active_d;

        logic [3:0]          n_c;
        logic [1:0]          o_c;
        logic                valid_c;
        logic                boundary_c;
        logic [DIV_W-1:0]    new_div_c;

        assign n_c        = note[4*i +: 4];
        assign o_c        = octave[2*i +: 2];
        assign valid_c    = (n_c >= 4'd1) && (n_c <= 4'd12);
        assign boundary_c = (cnt_q == div_q);
        assign new_div_c  = BASE[n_c] >> o_c;

        // Next-state and next-output logic.
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            div_d      = div_q;
            hold_d     = hold_q;
            lat_note_d = lat_note_q;
            lat_oct_d  = lat_oct_q;
            tone_d     = tone_q;

            case (state_q)
                IDLE: begin
                    if (valid_c) begin
                        state_d    = PLAY;
                        div_d      = new_div_c;
                        lat_note_d = n_c;
                        lat_oct_d  = o_c;
                        cnt_d      = '0;
                    end
                end
                PLAY: begin
                    if (boundary_c) begin
                        cnt_d  = '0;
                        tone_d = ~tone_q;
                        if (valid_c && ((n_c != lat_note_q) || (o_c != lat_oct_q))) begin
                            div_d      = new_div_c;
                            lat_note_d = n_c;
                            lat_oct_d  = o_c;
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                    if (!valid_c) begin
                        if (HOLD_CYC != 0) begin
                            state_d = RELEASE;
                            hold_d  = HOLD_W'(HOLD_CYC);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            tone_d  = 1'b0;
                            div_d   = '0;
                            hold_d  = '0;
                        end
                    end
                end
                RELEASE: begin
                    hold_d = hold_q - HOLD_W'(1);
                    if (boundary_c) begin
                        cnt_d  = '0;
                        tone_d = ~tone_q;
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                    // Re-press restarts the half-period at the new pitch, level untouched.
                    if (valid_c) begin
                        state_d    = PLAY;
                        div_d      = new_div_c;
                        lat_note_d = n_c;
                        lat_oct_d  = o_c;
                        cnt_d      = '0;
                        tone_d     = tone_q;
                        hold_d     = '0;
                    end else if (hold_q == HOLD_W'(1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        tone_d  = 1'b0;
                        div_d   = '0;
                        hold_d  = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tone_d  = 1'b0;
                    div_d   = '0;
                    hold_d  = '0;
                end
            endcase

            if (stop) begin
                state_d    = IDLE;
                cnt_d      = '0;
                tone_d     = 1'b0;
                div_d      = '0;
                hold_d     = '0;
                lat_note_d = '0;
                lat_oct_d  = '0;
            end

            active_d = (state_d != IDLE);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                div_q      <= '0;
                hold_q     <= '0;
                lat_note_q <= '0;
                lat_oct_q  <= '0;
                tone_q     <= 1'b0;
                active_q   <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                div_q      <= div_d;
                hold_q     <= hold_d;
                lat_note_q <= lat_note_d;
                lat_oct_q  <= lat_oct_d;
                tone_q     <= tone_d;
                active_q   <= active_d;
            end
        end

        assign tone_out[i]               = tone_q;
        assign active[i]                 = active_q;
        assign cur_div[DIV_W*i +: DIV_W] = div_q;
    end

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen: expectations queued with each stimulus step and
// popped against observed outputs or measured half-period lengths.
module tb_note_tone_gen;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DIV_W  = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    stop;
    logic [4*NUM_CH-1:0]     note;
    logic [2*NUM_CH-1:0]     octave;
    logic [NUM_CH-1:0]       tone_out, active, tone_z, active_z;
    logic [DIV_W*NUM_CH-1:0] cur_div, cur_div_z;

    always #5 clk = ~clk;

    note_tone_gen #(.NUM_CH(NUM_CH), .CLK_HZ(5240), .DIV_W(DIV_W), .HOLD_CYC(20)) u_dut (
        .clk(clk), .rst(rst), .stop(stop), .note(note), .octave(octave),
        .tone_out(tone_out), .active(active), .cur_div(cur_div)
    );

    note_tone_gen #(.NUM_CH(NUM_CH), .CLK_HZ(5240), .DIV_W(DIV_W), .HOLD_CYC(0)) u_dut_nohold (
        .clk(clk), .rst(rst), .stop(stop), .note(note), .octave(octave),
        .tone_out(tone_z), .active(active_z), .cur_div(cur_div_z)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n;

    localparam int MEAS = -1;

    function automatic logic [31:0] obs(input int sel, input int meas);
        case (sel)
            0:       return 32'(tone_out[0]);
            1:       return 32'(tone_out[1]);
            2:       return 32'(active[0]);
            3:       return 32'(active[1]);
            4:       return 32'(cur_div[7:0]);
            5:       return 32'(cur_div[15:8]);
            6:       return 32'(active_z[0]);
            7:       return 32'(tone_z[0]);
            8:       return 32'(cur_div_z[7:0]);
            default: return 32'(meas);
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel, input int exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = 32'(exp);
        sb.push_back(e);
    endtask

    task automatic check(input int meas = 0);
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel, meas);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic tick(input int cycles = 1);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until tone_out[ch] reaches lvl; a missing edge surfaces as the 200 cap.
    task automatic wait_lvl(input int ch, input logic lvl, output int cnt);
        cnt = 0;
        while (tone_out[ch] !== lvl && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic set_note(input int ch, input int nv, input int ov);
        note[4*ch +: 4]   = 4'(nv);
        octave[2*ch +: 2] = 2'(ov);
    endtask

    initial begin
        rst = 1'b1; stop = 1'b0; note = '0; octave = '0;
        tick(2);
        expect_v("rst_tone0", 0, 0);   expect_v("rst_tone1", 1, 0);
        expect_v("rst_act0", 2, 0);    expect_v("rst_act1", 3, 0);
        expect_v("rst_div0", 4, 0);    expect_v("rst_div1", 5, 0);
        check();

        // Basic C, octave 0
        rst = 1'b0;
        set_note(0, 1, 0);
        tick();
        expect_v("t1_act0", 2, 1); expect_v("t1_div0", 4, 9); expect_v("t1_z_div0", 8, 9);
        check();
        wait_lvl(0, 1'b1, n); expect_v("t1_first_rise", MEAS, 10); check(n);
        wait_lvl(0, 1'b0, n); expect_v("t1_high_half", MEAS, 10); check(n);
        wait_lvl(0, 1'b1, n); expect_v("t1_low_half", MEAS, 10); check(n);

        // Octave shift on ch0, A on ch1 with offset phase
        stop = 1'b1;
        tick();
        expect_v("t2_stop_tone0", 0, 0); expect_v("t2_stop_act0", 2, 0); check();
        stop = 1'b0;
        set_note(0, 1, 1);
        tick();
        expect_v("t2_div0", 4, 4); check();
        tick(2);
        set_note(1, 10, 0);
        tick();
        expect_v("t2_act1", 3, 1); expect_v("t2_div1", 5, 4); check();
        wait_lvl(0, 1'b1, n);
        expect_v("t2_ch0_rise", MEAS, 2); expect_v("t2_ch1_lvl", 1, 0); check(n);
        wait_lvl(1, 1'b1, n);
        expect_v("t2_ch1_rise", MEAS, 3); expect_v("t2_ch0_lvl", 0, 1); check(n);
        wait_lvl(1, 1'b0, n); expect_v("t2_ch1_high", MEAS, 5); check(n);
        wait_lvl(1, 1'b1, n); expect_v("t2_ch1_low", MEAS, 5); check(n);

        // Pitch change mid half-period; note held under stop stays idle
        stop = 1'b1;
        set_note(1, 0, 0);
        set_note(0, 1, 0);
        tick();
        expect_v("t5_stop_held", 2, 0); expect_v("t5_stop_div", 4, 0); check();
        stop = 1'b0;
        tick();
        expect_v("t3_act0", 2, 1); expect_v("t3_div0", 4, 9); check();
        tick(3);
        set_note(0, 10, 0);
        wait_lvl(0, 1'b1, n);
        expect_v("t3_finish_half", MEAS, 7); expect_v("t3_new_div", 4, 4); check(n);
        wait_lvl(0, 1'b0, n); expect_v("t3_short_high", MEAS, 5); check(n);
        wait_lvl(0, 1'b1, n); expect_v("t3_short_low", MEAS, 5); check(n);

        // Key-up: 20-cycle release tail keeps toggling at div 4
        set_note(0, 0, 0);
        tick();
        expect_v("t4_rel_act", 2, 1); check();
        tick(3);
        expect_v("t4_rel_tone_hi", 0, 1); check();
        tick();
        expect_v("t4_rel_tone_lo", 0, 0); check();
        tick(15);
        expect_v("t4_rel_last_act", 2, 1); expect_v("t4_rel_last_tone", 0, 1); check();
        tick();
        expect_v("t4_idle_act", 2, 0); expect_v("t4_idle_tone", 0, 0);
        expect_v("t4_idle_div", 4, 0); check();

        // Re-press at release cycle 10
        set_note(0, 10, 0);
        tick();
        expect_v("t4b_act", 2, 1); expect_v("t4b_div", 4, 4); check();
        wait_lvl(0, 1'b1, n); expect_v("t4b_rise", MEAS, 5); check(n);
        set_note(0, 0, 0);
        tick(10);
        expect_v("t4b_rel_act", 2, 1); expect_v("t4b_rel_tone", 0, 1); check();
        set_note(0, 1, 0);
        tick();
        expect_v("t4b_repress_act", 2, 1); expect_v("t4b_repress_div", 4, 9);
        expect_v("t4b_repress_lvl", 0, 1); check();
        wait_lvl(0, 1'b0, n); expect_v("t4b_new_half", MEAS, 10); check(n);

        // Stop during PLAY and during RELEASE
        stop = 1'b1;
        tick();
        expect_v("t5_play_tone", 0, 0); expect_v("t5_play_act", 2, 0);
        expect_v("t5_play_div", 4, 0); check();
        tick();
        expect_v("t5_held_act", 2, 0); check();
        stop = 1'b0;
        tick();
        expect_v("t5_restart_act", 2, 1); expect_v("t5_restart_div", 4, 9); check();
        set_note(0, 0, 0);
        tick(4);
        expect_v("t5_rel_act", 2, 1); check();
        stop = 1'b1;
        tick();
        expect_v("t5_rel_stop_act", 2, 0); expect_v("t5_rel_stop_tone", 0, 0);
        expect_v("t5_rel_stop_div", 4, 0); check();
        stop = 1'b0;

        // Note 13 as key-up; no-tail instance drops to idle at once
        set_note(0, 1, 0);
        tick();
        expect_v("t6_act", 2, 1); expect_v("t6_z_act", 6, 1); check();
        tick(2);
        set_note(0, 13, 0);
        tick();
        expect_v("t6_rel_act", 2, 1); expect_v("t6_rel_div", 4, 9);
        expect_v("t6_z_idle_act", 6, 0); expect_v("t6_z_idle_tone", 7, 0);
        expect_v("t6_z_idle_div", 8, 0); check();
        tick(19);
        expect_v("t6_tail_end_act", 2, 1); check();
        tick();
        expect_v("t6_tail_idle", 2, 0); check();

        // Reset mid-PLAY with notes held
        set_note(0, 1, 0);
        set_note(1, 10, 0);
        tick(12);
        expect_v("t6_pre_rst_act1", 3, 1); check();
        rst = 1'b1;
        tick();
        expect_v("t6_rst_tone0", 0, 0); expect_v("t6_rst_tone1", 1, 0);
        expect_v("t6_rst_act0", 2, 0);  expect_v("t6_rst_act1", 3, 0);
        expect_v("t6_rst_div0", 4, 0);  expect_v("t6_rst_div1", 5, 0);
        check();
        rst = 1'b0;
        tick();
        expect_v("t6_post_rst_act0", 2, 1); expect_v("t6_post_rst_div1", 5, 4); check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
